// File: rtl/scan_stream_reader_pkg.sv
// Shared types and constants for the scanner-to-stream reader and its skid FIFO.
// The FSM encoding is fixed at 3 bits so that other blocks can decode busy/state directly.
package scan_stream_reader_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 16;
   localparam int CNT_W      = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRIME = 3'd1,
      ST_FILL  = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // True when the buffer is, or is about to become, empty given this cycle's pop.
   function automatic logic fifo_drains(input logic [CNT_W-1:0] cnt, input logic pop);
      return (cnt == 2'd0) || ((cnt == 2'd1) && pop);
   endfunction

endpackage

// File: rtl/scan_stream_reader_if.sv
// Bundle of the scanner pull port and the downstream valid/ready stream.
// The master side is the reader; the slave side is the scanner plus downstream consumer.
interface scan_stream_reader_if
   import scan_stream_reader_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              last;
   logic              ready;
   logic              scan_reset;
   logic              scan_next;
   logic [DATA_W-1:0] scan_value;

   modport master (
      output data, valid, last, scan_reset, scan_next,
      input  ready, scan_value
   );

   modport slave (
      input  data, valid, last, scan_reset, scan_next,
      output ready, scan_value
   );
endinterface

// File: rtl/scan_stream_reader_fifo.sv
// Two-entry FIFO with registered head/valid/full outputs; push and pop may coincide at any occupancy.
// An empty FIFO keeps presenting its last head word.
module stream_skid_fifo
   import scan_stream_reader_pkg::*;
#(
   parameter int W = 33
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [W-1:0]     din_i,
   input  logic             pop_i,
   output logic [W-1:0]     dout_o,
   output logic             valid_o,
   output logic             full_o,
   output logic [CNT_W-1:0] count_o
);

   logic [W-1:0]     head_q, head_d;
   logic [W-1:0]     tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, full_q;
   logic             pop_eff_s, push_eff_s;

   // Next-state of storage and occupancy.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      pop_eff_s  = pop_i && (count_q != 2'd0);
      // A pop at full frees the slot, so the coincident push is still taken.
      push_eff_s = push_i && ((count_q != 2'd2) || pop_eff_s);
      case ({push_eff_s, pop_eff_s})
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d = din_i;
            end else begin
               tail_d = din_i;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            if (count_q == 2'd2) begin
               head_d = tail_q;
            end else begin
               head_d = head_q;
            end
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd2) begin
               head_d = tail_q;
               tail_d = din_i;
            end else begin
               head_d = din_i;
            end
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   // Storage and registered status flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
         valid_q <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= (count_d != 2'd0);
         full_q  <= (count_d == 2'd2);
      end
   end

   assign dout_o  = head_q;
   assign valid_o = valid_q;
   assign full_o  = full_q;
   assign count_o = count_q;

endmodule

// File: rtl/scan_stream_reader.sv
// Pulls one burst of words from a sequential memory scanner and emits them as a valid/ready stream.
// A 2-entry FIFO keeps the scanner enable independent of downstream ready while sustaining 1 word/cycle.
module scan_stream_reader
   import scan_stream_reader_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [LEN_W-1:0]       len_i,
   output logic                   busy_o,
   output logic                   done_o,
   scan_stream_reader_if.master   bus
);

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;

   logic               scan_reset_s;
   logic               scan_next_s;
   logic               busy_s;
   logic               done_s;
   logic               pop_s;
   logic               fifo_valid_s;
   logic               fifo_full_s;
   logic [CNT_W-1:0]   fifo_count_s;
   logic [DATA_W:0]    fifo_din_s;
   logic [DATA_W:0]    fifo_dout_s;

   // State and burst counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
      end
   end

   // Next-state and remaining-count logic.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               remaining_d = len_i;
               if (len_i != '0) begin
                  state_d = ST_PRIME;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRIME: state_d = ST_FILL;
         ST_FILL:  state_d = ST_RUN;
         ST_RUN: begin
            if (scan_next_s) begin
               remaining_d = remaining_q - LEN_W'(1);
            end else begin
               remaining_d = remaining_q;
            end
            // Leave as soon as the final word is being popped so done lands right after it.
            if ((remaining_q == '0) && fifo_drains(fifo_count_s, pop_s)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output decode from registered state, count and remaining only.
   always_comb begin
      scan_reset_s = 1'b0;
      scan_next_s  = 1'b0;
      busy_s       = 1'b1;
      done_s       = 1'b0;
      case (state_q)
         ST_IDLE:  busy_s       = 1'b0;
         ST_PRIME: scan_reset_s = 1'b1;
         ST_FILL:  scan_next_s  = 1'b0;
         ST_RUN:   scan_next_s  = (remaining_q != '0) && (fifo_count_s < 2'd2);
         ST_DONE:  done_s       = 1'b1;
         default:  busy_s       = 1'b0;
      endcase
   end

   assign pop_s      = fifo_valid_s && bus.ready;
   assign fifo_din_s = {(remaining_q == LEN_W'(1)), bus.scan_value};

   stream_skid_fifo #(
      .W (DATA_W + 1)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (scan_next_s),
      .din_i   (fifo_din_s),
      .pop_i   (pop_s),
      .dout_o  (fifo_dout_s),
      .valid_o (fifo_valid_s),
      .full_o  (fifo_full_s),
      .count_o (fifo_count_s)
   );

   assign busy_o         = busy_s;
   assign done_o         = done_s;
   assign bus.scan_reset = scan_reset_s;
   assign bus.scan_next  = scan_next_s;
   assign bus.data       = fifo_dout_s[DATA_W-1:0];
   assign bus.last       = fifo_dout_s[DATA_W];
   assign bus.valid      = fifo_valid_s;

endmodule
